// File: rtl/ps2_key_event_decoder.sv
// Set-2 scan-code decoder feeding a first-word-fall-through event FIFO.
// Latency: an event is visible on evt_* one cycle after the edge that samples its final byte.
// Backpressure: the FIFO pops only on evt_valid & evt_ready. A push into a full FIFO drops the event and sets the sticky overflow flag.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic make repeats.

// Generic synchronous FIFO. Head entry is read straight from registered storage.
// Latency: a write is visible on rd_dat/rd_vld the cycle after the write edge.
// Backpressure: wr_rdy drops when full, unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_vld,
  input  logic [WIDTH-1:0]  wr_dat,
  output logic              wr_rdy,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [WIDTH-1:0]  rd_dat,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              full;
  logic              push;
  logic              pop;

  // Status and handshake. A pop on a full FIFO frees the slot for the same-cycle push.
  always_comb begin
    full   = (count_q == DEPTH_CNT);
    rd_vld = (count_q != '0);
    pop    = rd_vld & rd_rdy;
    wr_rdy = ~full | pop;
    push   = wr_vld & wr_rdy;
    rd_dat = mem_q[rd_ptr_q];
    count  = count_q;
  end

  // Storage, pointers and occupancy. Storage is cleared so the head reads zero after reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_dat;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// Decodes E0/F0/E1 prefixed set-2 scan codes into {ext, brk, code} events.
// Latency: one cycle from the final byte strobe to evt_valid.
// Backpressure: holds events until evt_ready. A full FIFO drops new events and sets overflow.
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_key_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic [ADDR_W:0]   evt_count,
  output logic              overflow,
  input  logic              clear_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  state_t     state_q, state_d;
  logic       ext_q, ext_d;
  logic [2:0] skip_q, skip_d;

  logic       dec_vld;
  evt_t       dec_evt;
  logic       push_vld;
  logic       push_rdy;
  evt_t       head;
  logic       ovf_q;

  // Decode state register. Any partial prefix sequence is lost on reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ext_q   <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic and event generation. Only strobed bytes advance the decoder.
  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    skip_d       = skip_q;
    dec_vld      = 1'b0;
    dec_evt.ext  = 1'b0;
    dec_evt.brk  = 1'b0;
    dec_evt.code = ps2_key_data;
    if (ps2_key_pressed) begin
      case (state_q)
        ST_IDLE: begin
          case (ps2_key_data)
            8'hE0: begin
              state_d = ST_EXT;
              ext_d   = 1'b1;
            end
            8'hF0: begin
              state_d = ST_BRK;
              ext_d   = 1'b0;
            end
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            // Keyboard status/ack/error bytes carry no key information.
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
              state_d = ST_IDLE;
            end
            default: begin
              dec_vld = 1'b1;
            end
          endcase
        end
        ST_EXT: begin
          case (ps2_key_data)
            8'hF0: begin
              state_d = ST_BRK;
              ext_d   = 1'b1;
            end
            8'hE0: begin
              state_d = ST_EXT;
            end
            default: begin
              dec_vld     = 1'b1;
              dec_evt.ext = 1'b1;
              state_d     = ST_IDLE;
              ext_d       = 1'b0;
            end
          endcase
        end
        ST_BRK: begin
          // A prefix after F0 is malformed: drop the whole sequence.
          if (ps2_key_data != 8'hE0 && ps2_key_data != 8'hF0) begin
            dec_vld     = 1'b1;
            dec_evt.ext = ext_q;
            dec_evt.brk = 1'b1;
          end
          state_d = ST_IDLE;
          ext_d   = 1'b0;
        end
        ST_SKIP: begin
          // Pause is E1 followed by seven fixed bytes; report it once as extended 77.
          if (skip_q == 3'd1) begin
            dec_vld      = 1'b1;
            dec_evt.ext  = 1'b1;
            dec_evt.code = 8'h77;
            state_d      = ST_IDLE;
            skip_d       = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ext_d   = 1'b0;
          skip_d  = '0;
        end
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] last_make_q;
  logic       held_q;
  logic       key_match;

  // Typematic filter: a repeated make of the key still held is not queued.
  always_comb begin
    key_match = (last_make_q == {dec_evt.ext, dec_evt.code});
    push_vld  = dec_vld & ~(~dec_evt.brk & held_q & key_match);
  end

  // Track the most recent make and whether that key is still down.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_make_q <= '0;
      held_q      <= 1'b0;
    end else if (dec_vld) begin
      if (!dec_evt.brk) begin
        if (!(held_q && key_match)) begin
          last_make_q <= {dec_evt.ext, dec_evt.code};
          held_q      <= 1'b1;
        end
      end else if (key_match) begin
        held_q <= 1'b0;
      end
    end
  end
`else
  assign push_vld = dec_vld;
`endif

  sync_fifo #(
    .WIDTH  ($bits(evt_t)),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_evt_fifo (
    .clock  (clock),
    .resetn (resetn),
    .wr_vld (push_vld),
    .wr_dat (dec_evt),
    .wr_rdy (push_rdy),
    .rd_vld (evt_valid),
    .rd_rdy (evt_ready),
    .rd_dat (head),
    .count  (evt_count)
  );

  // Present the FIFO head as the current event.
  always_comb begin
    evt_code  = head.code;
    evt_ext   = head.ext;
    evt_break = head.brk;
    overflow  = ovf_q;
  end

  // Sticky drop flag. A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      ovf_q <= 1'b1;
    end else if (clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: sequence-level reference model plus directed literal checks.
module tb_ps2_key_event_decoder;

  localparam int DEPTH = 8;
`ifdef PS2_REPEAT_FILTER_EN
  localparam int EXP_T6 = 2;
`else
  localparam int EXP_T6 = 4;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [3:0] evt_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  ps2_key_event_decoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_code        (evt_code),
    .evt_ext         (evt_ext),
    .evt_break       (evt_break),
    .evt_count       (evt_count),
    .overflow        (overflow),
    .clear_ovf       (clear_ovf)
  );

  // ---------------- reference model ----------------
  logic [9:0] mq[$];   // queued events {ext, brk, code}
  logic [7:0] seq[$];  // bytes of the sequence currently being assembled
  bit         m_ovf = 1'b0;
  bit         m_held = 1'b0;
  logic [8:0] m_last = '0;

  function automatic bit is_discard(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
  endfunction

  function automatic bit seq_has(input logic [7:0] b, input int upto);
    for (int i = 0; i < upto; i++) if (seq[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Interpret the accumulated byte sequence as a whole rather than step by step.
  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev);
    emit = 1'b0;
    ev = '0;
    if (seq.size() == 0 && is_discard(b)) return;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        emit = 1'b1;
        ev = {1'b1, 1'b0, 8'h77};
        seq.delete();
      end
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (seq_has(8'hF0, seq.size() - 1)) seq.delete();
    end else begin
      emit = 1'b1;
      ev = {seq_has(8'hE0, seq.size()), seq_has(8'hF0, seq.size()), b};
      seq.delete();
    end
  endtask

  always @(posedge clock) begin
    bit         emit;
    logic [9:0] ev;
    bit         do_pop;
    if (!resetn) begin
      mq.delete();
      seq.delete();
      m_ovf = 1'b0;
      m_held = 1'b0;
      m_last = '0;
    end else begin
      emit = 1'b0;
      ev = '0;
      if (ps2_key_pressed) model_byte(ps2_key_data, emit, ev);
`ifdef PS2_REPEAT_FILTER_EN
      if (emit) begin
        if (!ev[8]) begin
          if (m_held && m_last == {ev[9], ev[7:0]}) emit = 1'b0;
          else begin
            m_last = {ev[9], ev[7:0]};
            m_held = 1'b1;
          end
        end else if (m_last == {ev[9], ev[7:0]}) begin
          m_held = 1'b0;
        end
      end
`endif
      do_pop = (mq.size() != 0) && evt_ready;
      if (do_pop) void'(mq.pop_front());
      if (emit && mq.size() >= DEPTH) m_ovf = 1'b1;
      else begin
        if (emit) mq.push_back(ev);
        if (clear_ovf) m_ovf = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    logic [9:0] h;
    if (cmp_en) begin
      chk("mdl_valid", {31'd0, evt_valid}, {31'd0, mq.size() != 0});
      chk("mdl_count", {28'd0, evt_count}, mq.size());
      chk("mdl_ovf", {31'd0, overflow}, {31'd0, m_ovf});
      if (mq.size() != 0) begin
        h = mq[0];
        chk("mdl_head", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, h});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data = b;
    tick();
    ps2_key_pressed = 1'b0;
  endtask

  task automatic pop1();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic chk_head(input string nm, input logic ext, input logic brk, input logic [7:0] code);
    chk({nm, "_valid"}, {31'd0, evt_valid}, 32'd1);
    chk({nm, "_head"}, {22'd0, evt_ext, evt_break, evt_code}, {22'd0, ext, brk, code});
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] t4_pops [8] = '{8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1E};

  initial begin
    @(posedge clock);
    cmp_en = 1'b1;
    #1;
    tick();
    resetn = 1'b1;
    tick();

    // reset state
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_count", {28'd0, evt_count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_head", {22'd0, evt_ext, evt_break, evt_code}, 32'd0);

    // 1: plain make, one-cycle latency, pop empties
    send(8'h1C);
    chk_head("t1", 1'b0, 1'b0, 8'h1C);
    pop1();
    chk("t1_popped", {31'd0, evt_valid}, 32'd0);

    // 2: extended break with idle gaps between bytes
    send(8'hE0);
    tick();
    chk("t2_e0", {28'd0, evt_count}, 32'd0);
    send(8'hF0);
    tick();
    chk("t2_f0", {28'd0, evt_count}, 32'd0);
    send(8'h75);
    chk_head("t2", 1'b1, 1'b1, 8'h75);
    chk("t2_count", {28'd0, evt_count}, 32'd1);
    pop1();

    // 3: normal break, then status bytes discarded
    send(8'hF0);
    send(8'h1C);
    chk_head("t3", 1'b0, 1'b1, 8'h1C);
    pop1();
    send(8'hAA);
    send(8'hFA);
    chk("t3_discard", {28'd0, evt_count}, 32'd0);

    // prefix after F0 is an error; the next byte is a fresh make
    send(8'hF0);
    send(8'hE0);
    chk("perr_none", {28'd0, evt_count}, 32'd0);
    send(8'h1C);
    chk_head("perr", 1'b0, 1'b0, 8'h1C);
    pop1();

    // 4: overflow, clear, full push+pop
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    chk("t4_count", {28'd0, evt_count}, 32'd8);
    chk("t4_ovf", {31'd0, overflow}, 32'd1);
    chk_head("t4_first", 1'b0, 1'b0, 8'h15);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("t4_clr", {31'd0, overflow}, 32'd0);
    evt_ready = 1'b1;
    send(8'h1E);
    evt_ready = 1'b0;
    chk("t4_pp_count", {28'd0, evt_count}, 32'd8);
    chk("t4_pp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_pop", {24'd0, evt_code}, {24'd0, t4_pops[i]});
      pop1();
    end
    chk("t4_empty", {28'd0, evt_count}, 32'd0);

    // 5: reset mid-sequence, then Pause
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk_head("t5_rst", 1'b0, 1'b0, 8'h1C);
    chk("t5_count", {28'd0, evt_count}, 32'd1);
    pop1();
    for (int i = 0; i < 7; i++) send(pause_seq[i]);
    chk("t5_pause_pend", {28'd0, evt_count}, 32'd0);
    send(pause_seq[7]);
    chk_head("t5_pause", 1'b1, 1'b0, 8'h77);
    chk("t5_pause_cnt", {28'd0, evt_count}, 32'd1);
    pop1();

    // 6: typematic repeats
    do_reset();
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    chk("t6_count", {28'd0, evt_count}, EXP_T6);
    for (int i = 0; i < 4; i++) pop1();
    chk("t6_empty", {28'd0, evt_count}, 32'd0);

    tick();
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
